interval_sequencer: RTL and testbench
=====================================

INTERVAL_SEQUENCER -- requirements
Module: interval_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count and terminal-value width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port syn_reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: in IDLE, begin a run; in PAUSE, resume.
REQ-005 The block SHALL have port pause, input, 1 bit: in RUN, freeze the count.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate any activity and return to IDLE.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = periodic; sampled only on a start accepted in IDLE.
REQ-008 The block SHALL have port load, input, 1 bit: write term_val to the terminal register.
REQ-009 The block SHALL have port term_val, input, WIDTH bits: terminal value.
REQ-010 The block SHALL have port count, output, WIDTH bits: current count.
REQ-011 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle terminal pulse.
REQ-014 The block SHALL have port done, output, 1 bit: one-shot completion pulse.

Function
REQ-015 The block SHALL update term_q from term_val on load only in IDLE; load in any other state SHALL be ignored.
REQ-016 In IDLE, count SHALL be 0; start with abort low SHALL move to RUN at the next edge and latch mode into mode_q.
REQ-017 In RUN, count SHALL increment by 1 per cycle while pause and abort are low.
REQ-018 tick SHALL be combinational: (state==RUN && count==term_q && !pause && !abort).
REQ-019 On a cycle with tick=1 and mode_q=1, the next edge SHALL set count to 0 and stay in RUN; the period SHALL be term_q+1 cycles.
REQ-020 On a cycle with tick=1 and mode_q=0, the next edge SHALL enter DONE with count held at term_q.
REQ-021 DONE SHALL last exactly one cycle with done=1; the next edge SHALL enter IDLE with count=0.
REQ-022 In RUN, pause=1 SHALL move to PAUSE; count SHALL hold its value and tick SHALL stay 0.
REQ-023 In PAUSE, start=1 with abort low SHALL return to RUN at the next edge; count SHALL resume from the held value.
REQ-024 abort=1 in any non-IDLE state SHALL enter IDLE at the next edge with count=0, producing no tick and no done.
REQ-025 Input priority SHALL be: abort > pause > terminal > increment.
REQ-026 Pause on the terminal cycle SHALL win: count holds at term_q; the terminal action occurs in the first RUN cycle after resume.
REQ-027 start in RUN or DONE, and pause outside RUN, SHALL be ignored.
REQ-028 With term_q=0: periodic mode SHALL give tick every RUN cycle with count constant 0; one-shot mode SHALL reach DONE after one RUN cycle.
REQ-029 Count SHALL never exceed term_q and SHALL never wrap through 2^WIDTH.

Reset
REQ-030 syn_reset=1 at a clk edge SHALL force: state=IDLE, count=0, term_q=all ones, mode_q=0, tick=0, done=0, busy=0.
REQ-031 syn_reset SHALL override all other inputs, including mid-run and mid-pause.

Structure
REQ-032 State encodings and the default terminal value SHALL be defined in a shared package, interval_seq_pkg.
REQ-033 The count register SHALL be one sub-module, cnt_core, with ports clk, syn_reset, ena and clr (WIDTH-bit, increment on ena, clear on clr).
REQ-034 The FSM SHALL drive cnt_core's ena and clr; no other logic SHALL write count.

Verification
REQ-035 Periodic: load 3, mode=1, start -> count 0,1,2,3,0,...; tick high whenever count=3 (every 4 cycles); busy=1.
REQ-036 One-shot: load 5, mode=0, start -> count 0..5; tick at count=5; next cycle DONE with done=1, count=5; then IDLE with count=0.
REQ-037 Pause on terminal: term 2, pause asserted while count=2 -> tick=0, state PAUSE, count 2 held 3 cycles; start -> tick in the first RUN cycle, then the terminal action.
REQ-038 Abort/priority: pause+abort together in RUN at count=1 -> IDLE, count=0, no done; start+abort together in IDLE -> remains IDLE.
REQ-039 Load gating: load 7 during RUN (term 3) -> wraps at 3; after returning to IDLE, load 7 -> next run wraps at 7.
REQ-040 Reset: syn_reset in PAUSE at count=4 -> next cycle IDLE, count=0, term_q=15; term_q=0 periodic -> tick every cycle.

Source files
------------

// File: rtl/interval_seq_pkg.sv
// rtl/interval_seq_pkg.sv - shared state encodings and reset constants for the interval sequencer
package interval_seq_pkg;

  // Encodings are visible on the state output, so they are fixed here
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Terminal register resets to all ones; replicated to WIDTH at the use site
  localparam logic TERM_DEFAULT_BIT = 1'b1;

endpackage

// File: rtl/interval_sequencer_cnt_core.sv
// rtl/interval_sequencer_cnt_core.sv - count register with clear and increment enable
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             syn_reset,
  input  logic             ena,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; otherwise hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (ena) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/interval_sequencer.sv
// rtl/interval_sequencer.sv - run/pause/abort interval sequencer with one-shot and periodic modes
module interval_sequencer
  import interval_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             syn_reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             cnt_ena;
  logic             cnt_clr;
  logic             at_term;

  // The FSM is the only writer of count, via ena/clr
  cnt_core #(.WIDTH(WIDTH)) u_cnt_core (
    .clk       (clk),
    .syn_reset (syn_reset),
    .ena       (cnt_ena),
    .clr       (cnt_clr),
    .count     (count)
  );

  assign at_term = (count == term_q);

  // State, latched mode and terminal value registers
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      term_q  <= {WIDTH{TERM_DEFAULT_BIT}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      term_q  <= term_d;
    end
  end

  // Next-state: abort > pause > terminal > increment; mode and term only change in IDLE
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    term_d  = term_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          term_d = term_val;
        end
        if (start && !abort) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (at_term && !mode_q) begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs and counter controls; count is held through PAUSE and DONE
  always_comb begin
    cnt_ena = 1'b0;
    cnt_clr = 1'b0;
    tick    = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          cnt_clr = 1'b1;
        end else if (!pause) begin
          if (at_term) begin
            tick    = 1'b1;
            cnt_clr = mode_q;
          end else begin
            cnt_ena = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        busy    = 1'b1;
        cnt_clr = abort;
      end
      ST_DONE: begin
        done    = 1'b1;
        cnt_clr = 1'b1;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_interval_sequencer.sv
// tb/tb_interval_sequencer.sv - directed self-checking bench for interval_sequencer
module tb_interval_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         syn_reset;
  logic         start;
  logic         pause;
  logic         abort;
  logic         mode;
  logic         load;
  logic [W-1:0] term_val;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy;
  logic         tick;
  logic         done;

  int n_checks;
  int n_errors;

  interval_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .syn_reset (syn_reset),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .mode      (mode),
    .load      (load),
    .term_val  (term_val),
    .count     (count),
    .state     (state),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int cnt,
                            input int bsy, input int tk, input int dn);
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".count"}, 32'(count), 32'(cnt));
    check_eq({tag, ".busy"},  32'(busy),  32'(bsy));
    check_eq({tag, ".tick"},  32'(tick),  32'(tk));
    check_eq({tag, ".done"},  32'(done),  32'(dn));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    syn_reset = 1'b1;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    mode = 1'b0; load = 1'b0; term_val = '0;
    cyc(); cyc();
    syn_reset = 1'b0;
    settle();
    expect_out("reset", 0, 0, 0, 0, 0);

    // Periodic, term 3
    load = 1'b1; term_val = 4'd3;
    cyc();
    load = 1'b0; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("per3[%0d]", i), 1, i % 4, 1, (i % 4 == 3) ? 1 : 0, 0);
      cyc();
    end
    abort = 1'b1;
    settle();
    check_eq("per3.abort_tick", 32'(tick), 32'd0);
    cyc();
    abort = 1'b0;
    settle();
    expect_out("per3.aborted", 0, 0, 0, 0, 0);

    // One-shot, term 5, then start in DONE ignored
    load = 1'b1; term_val = 4'd5;
    cyc();
    load = 1'b0; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int i = 0; i < 6; i++) begin
      expect_out($sformatf("one5[%0d]", i), 1, i, 1, (i == 5) ? 1 : 0, 0);
      cyc();
    end
    start = 1'b1;
    settle();
    expect_out("one5.done", 3, 5, 0, 0, 1);
    cyc();
    start = 1'b0;
    settle();
    expect_out("one5.idle", 0, 0, 0, 0, 0);

    // Pause on terminal, mode change on resume must not matter
    load = 1'b1; term_val = 4'd2;
    cyc();
    load = 1'b0; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    pause = 1'b1;
    settle();
    expect_out("pt.pause_req", 1, 2, 1, 0, 0);
    cyc();
    pause = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("pt.held[%0d]", i), 2, 2, 1, 0, 0);
      cyc();
    end
    mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; mode = 1'b0;
    settle();
    expect_out("pt.resume", 1, 2, 1, 1, 0);
    cyc();
    expect_out("pt.done", 3, 2, 0, 0, 1);
    cyc();
    expect_out("pt.idle", 0, 0, 0, 0, 0);

    // Abort priority over pause, and over start in IDLE
    load = 1'b1; term_val = 4'd3;
    cyc();
    load = 1'b0; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    pause = 1'b1; abort = 1'b1;
    settle();
    expect_out("ab.req", 1, 1, 1, 0, 0);
    cyc();
    pause = 1'b0;
    start = 1'b1;
    settle();
    expect_out("ab.idle", 0, 0, 0, 0, 0);
    cyc();
    start = 1'b0; abort = 1'b0;
    settle();
    expect_out("ab.start_blocked", 0, 0, 0, 0, 0);

    // Load gating: load during RUN ignored
    mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    load = 1'b1; term_val = 4'd7;
    cyc();
    load = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("lg.run[%0d]", i), 1, (i + 1) % 4, 1, ((i + 1) % 4 == 3) ? 1 : 0, 0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    load = 1'b1; term_val = 4'd7;
    cyc();
    load = 1'b0; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int i = 0; i < 9; i++) begin
      expect_out($sformatf("lg.t7[%0d]", i), 1, i % 8, 1, (i % 8 == 7) ? 1 : 0, 0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Reset in PAUSE at count 4 restores term 15
    mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    settle();
    expect_out("rst.paused", 2, 4, 1, 0, 0);
    syn_reset = 1'b1; start = 1'b1;
    cyc();
    syn_reset = 1'b0; start = 1'b0;
    settle();
    expect_out("rst.idle", 0, 0, 0, 0, 0);
    mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int i = 0; i < 17; i++) begin
      expect_out($sformatf("rst.t15[%0d]", i), 1, i % 16, 1, (i % 16 == 15) ? 1 : 0, 0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // term 0: periodic ticks every cycle; one-shot finishes after one RUN cycle
    load = 1'b1; term_val = 4'd0;
    cyc();
    load = 1'b0; mode = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("t0p[%0d]", i), 1, 0, 1, 1, 0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0; mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    expect_out("t0o.run", 1, 0, 1, 1, 0);
    cyc();
    expect_out("t0o.done", 3, 0, 0, 0, 1);
    cyc();
    expect_out("t0o.idle", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
